avalon_pio_gen: RTL and testbench
=================================

Name: avalon_pio_gen

Overview:
- Parametrised Avalon-MM slave general-purpose I/O port; successor to the fixed 8-bit output-only PIO.
- Adds:
  - configurable width;
  - per-bit direction;
  - synchronised input sampling;
  - per-bit edge capture with write-1-to-clear;
  - atomic bit set/clear of the output register;
  - maskable, registered level interrupt.
- Sits on the system interconnect between the CPU data master and board pins (LEDs, switches, keys).

Parameters:
- WIDTH, 8, number of I/O bits (1..32).
- RESET_VALUE, 0, value of the output data register after reset (WIDTH bits).
- EDGE_MODE, 0, edge that sets edgecapture: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  register word select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  read data, combinational, read latency 0.
- in_port  input  WIDTH  asynchronous pin inputs.
- out_port  output  WIDTH  output data register.
- oe  output  WIDTH  per-bit output enable (1 = drive pin), equals the direction register.
- irq  output  1  active-high level interrupt, registered.

Behaviour:
- Reset is asynchronous, asserted when reset_n is low, released synchronously to clk.
  - Reset values: data_out = RESET_VALUE, direction = 0, irqmask = 0, edgecapture = 0, sync stages = 0, irq = 0.
  - Outputs after reset: out_port = RESET_VALUE, oe = 0, readdata = 0 unless selected.
- Write strobe: a write occurs on a rising clk edge when chipselect = 1, write_n = 0. No wait states.
- Only writedata[WIDTH-1:0] is used. Bits at and above WIDTH read as 0.
- Register map (word address):
  - 0 DATA
    - read: synchronised in_port (sync2).
    - write: data_out <= writedata.
  - 1 DIRECTION, read/write, drives oe.
  - 2 IRQMASK, read/write.
  - 3 EDGECAPTURE
    - read: the capture bits.
    - write: each bit written 1 is cleared; bits written 0 are unchanged.
  - 4 OUTSET
    - write: data_out <= data_out | writedata.
    - read returns 0.
  - 5 OUTCLEAR
    - write: data_out <= data_out & ~writedata.
    - read returns 0.
  - 6, 7: reserved. Writes ignored, reads 0.
- readdata:
  - combinational mux of the addressed register, zero-extended to 32 bits;
  - forced to 0 when chipselect = 0;
  - reads have no side effects.
- Input path:
  - 2-flop synchroniser in_port -> sync1 -> sync2, plus a history register prev <= sync2.
  - Per-bit edge detect:
    - rising: sync2 & ~prev;
    - falling: ~sync2 & prev;
    - any: sync2 ^ prev.
  - Input sampling applies to all bits regardless of direction.
- Timing, for an in_port change set up before clk edge k:
  - DATA read reflects the new value after edge k+1;
  - edgecapture bit sets at edge k+2;
  - irq asserts at edge k+3 if the bit is unmasked.
- Edgecapture:
  - set is sticky until cleared by a write of 1;
  - a detected edge and a write-1-clear on the same bit in the same cycle: set wins, bit stays 1.
- irq:
  - irq <= |(edgecapture & irqmask), evaluated each clk;
  - deasserts one cycle after the clearing write or the mask write.
- A pulse shorter than one clk period may be missed. This is not required to be detected.
- Consecutive back-to-back writes to different registers in adjacent cycles must all take effect.
- Reset asserted mid-operation:
  - all state returns to reset values immediately;
  - pending edges are discarded;
  - no edge is detected on the first post-reset sample unless in_port differs from 0 for two cycles (prev resets to 0). With EDGE_MODE 0, a pin held high through reset therefore produces one capture after release.

Test Plan:
- Reset with WIDTH = 8, RESET_VALUE = 8'hA5 -> out_port = 8'hA5, oe = 0, irq = 0; reads of addresses 1, 2, 3 return 0.
- Write DATA = 32'hFFFF_FF3C -> out_port = 8'h3C, DATA-side bits above 7 ignored. Then OUTSET = 8'h81 -> out_port = 8'hBD. Then OUTCLEAR = 8'h0C -> out_port = 8'hB1. Reads of addresses 4, 5 return 0.
- Write DIRECTION = 8'h0F -> oe = 8'h0F. in_port = 8'h5A held -> DATA read returns 32'h0000_005A two edges after the change.
- EDGE_MODE 0, IRQMASK = 8'h01, in_port[0] rises before edge k:
  - EDGECAPTURE reads 8'h01 after k+2;
  - irq = 1 after k+3;
  - write EDGECAPTURE = 8'h01 -> irq = 0 one cycle later.
- Set versus clear: new rising edge on bit 2 in the same cycle as a write-1-clear of bit 2 -> EDGECAPTURE bit 2 stays 1. With EDGE_MODE 2, a falling edge on bit 3 also sets bit 3.
- Assert reset_n low mid-sequence with edgecapture = 8'h05 and irq = 1 -> both 0 immediately, out_port = RESET_VALUE. Masked edge (IRQMASK = 0) -> capture bit sets, irq remains 0.

Source files
------------

// File: rtl/avalon_pio_gen.sv
// avalon_pio_gen: Avalon-MM GPIO slave with per-bit direction, synchronised inputs,
// edge capture (write-1-to-clear), atomic output set/clear and a maskable level irq.
module avalon_pio_gen #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_MODE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);
   logic [WIDTH-1:0] data_out_q, data_out_d, dir_q, dir_d, mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d, sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic             irq_q, irq_d;
   logic             wr;
   logic [WIDTH-1:0] wd, edge_det, rd_w;
   logic             unused_wd;

   assign unused_wd = ^writedata;

   always_comb begin
      wr         = chipselect & ~write_n;
      wd         = writedata[WIDTH-1:0];
      sync1_d    = in_port;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      edge_det   = (EDGE_MODE == 0) ? (sync2_q & ~prev_q) :
                   (EDGE_MODE == 1) ? (~sync2_q & prev_q) : (sync2_q ^ prev_q);
      data_out_d = !wr              ? data_out_q :
                   address == 3'd0  ? wd :
                   address == 3'd4  ? (data_out_q | wd) :
                   address == 3'd5  ? (data_out_q & ~wd) : data_out_q;
      dir_d      = (wr && address == 3'd1) ? wd : dir_q;
      mask_d     = (wr && address == 3'd2) ? wd : mask_q;
      // a new edge in the same cycle as a clear keeps the bit set
      cap_d      = (cap_q & ~((wr && address == 3'd3) ? wd : '0)) | edge_det;
      irq_d      = |(cap_q & mask_q);
      rd_w       = address == 3'd0 ? sync2_q :
                   address == 3'd1 ? dir_q :
                   address == 3'd2 ? mask_q :
                   address == 3'd3 ? cap_q : '0;
      readdata   = '0;
      readdata[WIDTH-1:0] = chipselect ? rd_w : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RESET_VALUE;
         dir_q      <= '0;
         mask_q     <= '0;
         cap_q      <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         irq_q      <= irq_d;
      end
   end

   assign out_port = data_out_q;
   assign oe       = dir_q;
   assign irq      = irq_q;
endmodule

// File: tb/tb_avalon_pio_gen.sv
// tb_avalon_pio_gen: directed checks of avalon_pio_gen with rising-edge and any-edge
// instances sharing one bus and one set of pins.
module tb_avalon_pio_gen;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] rd0, rd2;
   logic [7:0]  out0, out2, oe0, oe2;
   logic        irq0, irq2;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   avalon_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
      .out_port(out0), .oe(oe0), .irq(irq0));

   avalon_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_MODE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
      .out_port(out2), .oe(oe2), .irq(irq2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      #1;
      chk(tag, rd0, exp);
      chipselect = 1'b0;
   endtask

   task automatic rdb(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      #1;
      chk(tag, rd2, exp);
      chipselect = 1'b0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      wait_n(2);
      chk("rst_out", 32'(out0), 32'hA5);
      chk("rst_oe", 32'(oe0), 32'h0);
      chk("rst_irq", 32'(irq0), 32'h0);
      reset_n = 1'b1;
      wait_n(1);
      rd("rst_dir", 3'd1, 32'h0);
      rd("rst_mask", 3'd2, 32'h0);
      rd("rst_cap", 3'd3, 32'h0);
      // output register: write, set, clear, reserved write ignored
      bus_wr(3'd0, 32'hFFFF_FF3C);
      chk("data_wr", 32'(out0), 32'h3C);
      bus_wr(3'd4, 32'h81);
      chk("outset", 32'(out0), 32'hBD);
      bus_wr(3'd5, 32'h0C);
      chk("outclr", 32'(out0), 32'hB1);
      bus_wr(3'd6, 32'hFF);
      chk("rsvd_wr", 32'(out0), 32'hB1);
      rd("rd_set", 3'd4, 32'h0);
      rd("rd_clr", 3'd5, 32'h0);
      rd("rd_rsvd", 3'd7, 32'h0);
      // direction and input sampling latency
      bus_wr(3'd1, 32'h0F);
      chk("oe", 32'(oe0), 32'h0F);
      rd("dir", 3'd1, 32'h0F);
      in_port = 8'h5A;
      wait_n(1);
      rd("data_early", 3'd0, 32'h0);
      wait_n(1);
      rd("data_in", 3'd0, 32'h5A);
      wait_n(1);
      rd("cap_5a", 3'd3, 32'h5A);
      rdb("cap_5a_any", 3'd3, 32'h5A);
      bus_wr(3'd3, 32'hFF);
      rd("cap_clr", 3'd3, 32'h0);
      rdb("cap_clr_any", 3'd3, 32'h0);
      // unmasked rising edge on bit 0 through to irq and its clear
      bus_wr(3'd2, 32'h01);
      in_port = 8'h5B;
      wait_n(2);
      rd("cap_k1", 3'd3, 32'h0);
      wait_n(1);
      rd("cap_k2", 3'd3, 32'h01);
      chk("irq_k2", 32'(irq0), 32'h0);
      wait_n(1);
      chk("irq_k3", 32'(irq0), 32'h1);
      bus_wr(3'd3, 32'h01);
      chk("irq_hold", 32'(irq0), 32'h1);
      wait_n(1);
      chk("irq_clr", 32'(irq0), 32'h0);
      // edge on bit 2 coincides with a write-1-clear of bit 2
      in_port = 8'h5F;
      wait_n(2);
      bus_wr(3'd3, 32'h04);
      rd("set_wins", 3'd3, 32'h04);
      chk("irq_b2", 32'(irq0), 32'h0);
      bus_wr(3'd3, 32'hFF);
      // falling edge on bit 3: only the any-edge instance captures
      in_port = 8'h57;
      wait_n(3);
      rd("fall_rise", 3'd3, 32'h0);
      rdb("fall_any", 3'd3, 32'h08);
      bus_wr(3'd3, 32'hFF);
      // build capture 0x05 with irq set, then reset mid-sequence
      in_port = 8'h52;
      wait_n(3);
      bus_wr(3'd3, 32'hFF);
      in_port = 8'h57;
      wait_n(4);
      rd("cap_05", 3'd3, 32'h05);
      chk("irq_pre", 32'(irq0), 32'h1);
      reset_n = 1'b0;
      #1;
      rd("mid_cap", 3'd3, 32'h0);
      chk("mid_irq", 32'(irq0), 32'h0);
      chk("mid_out", 32'(out0), 32'hA5);
      chk("mid_oe", 32'(oe0), 32'h0);
      wait_n(1);
      reset_n = 1'b1;
      // pins held high through reset give one capture; mask is 0 so no irq
      wait_n(3);
      rd("post_cap", 3'd3, 32'h57);
      wait_n(1);
      chk("post_irq", 32'(irq0), 32'h0);
      // back-to-back writes to different registers
      bus_wr(3'd1, 32'hAA);
      bus_wr(3'd2, 32'h55);
      bus_wr(3'd0, 32'h12);
      chk("b2b_oe", 32'(oe0), 32'hAA);
      chk("b2b_out", 32'(out0), 32'h12);
      chk("b2b_out_any", 32'(out2), 32'h12);
      rd("b2b_mask", 3'd2, 32'h55);
      wait_n(1);
      chk("b2b_irq", 32'(irq0), 32'h1);
      address = 3'd1;
      chipselect = 1'b0;
      #1;
      chk("no_cs", rd0, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
